mem_stage: RTL and testbench

- MEM pipeline stage of the RV32I core; consumes the EX/MEM register contents (result/address, store data, memory op type, destination).
- Drives a byte-wide single-port RAM, serialising LB/LH/LW/LBU/LHU and SB/SH/SW into 1-4 byte accesses.
- Raises a stall request while an access is in flight.
- Produces the writeback triple and the MEM-stage forwarding triple for ID.

---
 rtl/mem_stage_pkg.sv | 34 +++
 rtl/mem_load_ext.sv | 23 ++
 rtl/mem_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the RV32I MEM stage: funct3 load/store codes, FSM states
// and the byte-count helper used to serialise accesses onto the byte-wide RAM.
package mem_stage_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
   localparam logic        RST_ENABLE    = 1'b1;
   localparam logic        WRITE_ENABLE  = 1'b1;
   localparam logic        WRITE_DISABLE = 1'b0;

   typedef enum logic {
      MEM_IDLE = 1'b0,
      MEM_BUSY = 1'b1
   } mem_state_e;

   // Size lives in funct3[1:0]; the unsigned bit doesn't change the byte count.
   function automatic logic [2:0] mem_nbytes(input logic [2:0] f3);
      case (f3[1:0])
         F3_SB[1:0]: return 3'd1;
         F3_SH[1:0]: return 3'd2;
         F3_SW[1:0]: return 3'd4;
         default:    return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load data extension: turns the assembled little-endian bytes into the
// architectural 32-bit load result according to funct3.
module mem_load_ext
   import mem_stage_pkg::*;
(
   input  logic [31:0] data_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] ext_o
);

   always_comb begin
      ext_o = data_i;
      case (funct3_i)
         F3_LB:   ext_o = {{24{data_i[7]}}, data_i[7:0]};
         F3_LBU:  ext_o = {24'h0, data_i[7:0]};
         F3_LH:   ext_o = {{16{data_i[15]}}, data_i[15:0]};
         F3_LHU:  ext_o = {16'h0, data_i[15:0]};
         F3_LW:   ext_o = data_i;
         default: ext_o = data_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: serialises loads/stores into 1-4 byte RAM accesses, stalls
// the pipe while an access is in flight and produces writeback/forwarding data.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        wd_i,
   input  logic              wreg_i,
   input  logic [31:0]       wdata_i,
   input  logic              is_load_i,
   input  logic              is_store_i,
   input  logic [2:0]        mem_op_type_i,
   input  logic [31:0]       mem_w_data_i,
   input  logic [7:0]        ram_din_i,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_wr_o,
   output logic [7:0]        ram_dout_o,
   output logic              stall_req_o,
   output logic [4:0]        wd_o,
   output logic              wreg_o,
   output logic [31:0]       wdata_o,
   output logic              mem_fwd_we_o,
   output logic [4:0]        mem_fwd_rd_o,
   output logic [31:0]       mem_fwd_data_o
);

   mem_state_e            state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [2:0][7:0]       buf_q, buf_d;

   logic                  is_ld, is_st;
   logic [2:0]            nbytes;
   logic [2:0]            byte_off;
   logic [1:0]            buf_idx;
   logic [3:0][7:0]       st_bytes;
   logic [3:0][7:0]       ld_bytes;
   logic [31:0]           ld_ext;

   logic                  wr, stall, wreg, fwd_block;
   logic [7:0]            dout;
   logic [31:0]           wdata;

   // A load+store combination is illegal upstream; load wins.
   assign is_ld    = is_load_i;
   assign is_st    = is_store_i & ~is_load_i;
   assign nbytes   = mem_nbytes(mem_op_type_i);
   assign st_bytes = mem_w_data_i;
   assign buf_idx  = 2'(cnt_q - 3'd1);

   // The byte arriving this cycle sits in lane cnt-1; earlier lanes come from buf.
   for (genvar j = 0; j < 4; j++) begin : g_lane
      if (j < 3) begin : g_buf
         assign ld_bytes[j] = (cnt_q == 3'(j + 1)) ? ram_din_i : buf_q[j];
      end else begin : g_top
         assign ld_bytes[j] = ram_din_i;
      end
   end

   mem_load_ext u_ext (
      .data_i   (ld_bytes),
      .funct3_i (mem_op_type_i),
      .ext_o    (ld_ext)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      buf_d     = buf_q;
      byte_off  = 3'd0;
      wr        = WRITE_DISABLE;
      dout      = 8'h00;
      stall     = 1'b0;
      wreg      = wreg_i;
      wdata     = wdata_i;
      fwd_block = 1'b0;
      case (state_q)
         MEM_IDLE: begin
            if (is_ld) begin
               stall     = 1'b1;
               fwd_block = 1'b1;
               state_d   = MEM_BUSY;
               cnt_d     = 3'd1;
            end else if (is_st) begin
               wr   = WRITE_ENABLE;
               dout = st_bytes[0];
               wreg = 1'b0;
               if (nbytes != 3'd1) begin
                  stall   = 1'b1;
                  state_d = MEM_BUSY;
                  cnt_d   = 3'd1;
               end
            end
         end
         MEM_BUSY: begin
            byte_off = cnt_q;
            if (is_ld) begin
               if (cnt_q == nbytes) begin
                  wdata   = ld_ext;
                  state_d = MEM_IDLE;
                  cnt_d   = 3'd0;
               end else begin
                  stall          = 1'b1;
                  fwd_block      = 1'b1;
                  buf_d[buf_idx] = ram_din_i;
                  cnt_d          = cnt_q + 3'd1;
               end
            end else if (is_st) begin
               wr   = WRITE_ENABLE;
               dout = st_bytes[byte_off[1:0]];
               wreg = 1'b0;
               if (cnt_q == nbytes - 3'd1) begin
                  state_d = MEM_IDLE;
                  cnt_d   = 3'd0;
               end else begin
                  stall = 1'b1;
                  cnt_d = cnt_q + 3'd1;
               end
            end else begin
               state_d = MEM_IDLE;
               cnt_d   = 3'd0;
            end
         end
         default: begin
            state_d = MEM_IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   always_comb begin
      ram_addr_o     = wdata_i[ADDR_W-1:0] + ADDR_W'(byte_off);
      ram_wr_o       = wr;
      ram_dout_o     = dout;
      stall_req_o    = stall;
      wd_o           = wd_i;
      wreg_o         = wreg;
      wdata_o        = wdata;
      mem_fwd_we_o   = wreg & ~fwd_block;
      mem_fwd_rd_o   = wd_i;
      mem_fwd_data_o = wdata;
      if (rst == RST_ENABLE) begin
         ram_addr_o     = '0;
         ram_wr_o       = WRITE_DISABLE;
         ram_dout_o     = 8'h00;
         stall_req_o    = 1'b0;
         wd_o           = 5'd0;
         wreg_o         = 1'b0;
         wdata_o        = ZERO_WORD;
         mem_fwd_we_o   = 1'b0;
         mem_fwd_rd_o   = 5'd0;
         mem_fwd_data_o = ZERO_WORD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q <= MEM_IDLE;
         cnt_q   <= 3'd0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a behavioural byte RAM (one-cycle read).
module tb_mem_stage;

   localparam int ADDR_W = 17;

   logic              clk = 1'b0;
   logic              rst;
   logic [4:0]        wd_i;
   logic              wreg_i;
   logic [31:0]       wdata_i;
   logic              is_load_i, is_store_i;
   logic [2:0]        mem_op_type_i;
   logic [31:0]       mem_w_data_i;
   logic [7:0]        ram_din_i;
   logic [ADDR_W-1:0] ram_addr_o;
   logic              ram_wr_o;
   logic [7:0]        ram_dout_o;
   logic              stall_req_o;
   logic [4:0]        wd_o;
   logic              wreg_o;
   logic [31:0]       wdata_o;
   logic              mem_fwd_we_o;
   logic [4:0]        mem_fwd_rd_o;
   logic [31:0]       mem_fwd_data_o;

   logic [7:0]        mem [0:(1<<ADDR_W)-1];
   logic              bd_we = 1'b0;
   logic [ADDR_W-1:0] bd_addr = '0;
   logic [7:0]        bd_data = 8'h00;

   int total = 0;
   int bad   = 0;

   mem_stage #(.ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .wd_i           (wd_i),
      .wreg_i         (wreg_i),
      .wdata_i        (wdata_i),
      .is_load_i      (is_load_i),
      .is_store_i     (is_store_i),
      .mem_op_type_i  (mem_op_type_i),
      .mem_w_data_i   (mem_w_data_i),
      .ram_din_i      (ram_din_i),
      .ram_addr_o     (ram_addr_o),
      .ram_wr_o       (ram_wr_o),
      .ram_dout_o     (ram_dout_o),
      .stall_req_o    (stall_req_o),
      .wd_o           (wd_o),
      .wreg_o         (wreg_o),
      .wdata_o        (wdata_o),
      .mem_fwd_we_o   (mem_fwd_we_o),
      .mem_fwd_rd_o   (mem_fwd_rd_o),
      .mem_fwd_data_o (mem_fwd_data_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (ram_wr_o) mem[ram_addr_o] <= ram_dout_o;
      ram_din_i <= mem[ram_addr_o];
   end

   always @(posedge clk)
      if (!rst) assert (!(is_load_i && is_store_i)) else $error("load and store both set");

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Checks happen mid-cycle so combinational outputs have settled.
   task automatic settle();
      #3;
   endtask

   task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] rd, input logic we);
      is_load_i = ld; is_store_i = st; mem_op_type_i = f3;
      wdata_i = a; mem_w_data_i = sd; wd_i = rd; wreg_i = we;
   endtask

   task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      step();
      bd_we = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b1, 1'b0, 3'b010, 32'h0000_0123, 32'hFFFF_FFFF, 5'd7, 1'b1);
      step();
      settle();
      chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
      chk("rst_wdata", wdata_o, 32'd0);
      chk("rst_wreg",  {31'd0, wreg_o}, 32'd0);
      chk("rst_addr",  {15'd0, ram_addr_o}, 32'd0);
      chk("rst_fwd",   {26'd0, mem_fwd_we_o, mem_fwd_rd_o}, 32'd0);

      poke(17'h00100, 8'h78); poke(17'h00101, 8'h56);
      poke(17'h00102, 8'h34); poke(17'h00103, 8'h12);
      poke(17'h00300, 8'h80);
      poke(17'h1FFFF, 8'hFF); poke(17'h00000, 8'h7F);

      // Non-memory pass-through
      rst = 1'b0;
      drive(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
      settle();
      chk("pt_wd",    {27'd0, wd_o}, 32'd5);
      chk("pt_wreg",  {31'd0, wreg_o}, 32'd1);
      chk("pt_wdata", wdata_o, 32'h1234);
      chk("pt_fwd",   {26'd0, mem_fwd_we_o, mem_fwd_rd_o}, {26'd0, 1'b1, 5'd5});
      chk("pt_fdata", mem_fwd_data_o, 32'h1234);
      chk("pt_ctl",   {30'd0, stall_req_o, ram_wr_o}, 32'd0);
      step();

      // LW 0x100
      drive(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd3, 1'b1);
      for (int c = 0; c < 4; c++) begin
         settle();
         chk($sformatf("lw_addr%0d", c), {15'd0, ram_addr_o}, 32'h100 + c);
         chk($sformatf("lw_stall%0d", c), {31'd0, stall_req_o}, 32'd1);
         chk($sformatf("lw_fwdwe%0d", c), {31'd0, mem_fwd_we_o}, 32'd0);
         step();
      end
      settle();
      chk("lw_data",  wdata_o, 32'h1234_5678);
      chk("lw_stall", {31'd0, stall_req_o}, 32'd0);
      chk("lw_fwd",   {mem_fwd_we_o, 26'd0, mem_fwd_rd_o}, {1'b1, 26'd0, 5'd3});
      chk("lw_fdata", mem_fwd_data_o, 32'h1234_5678);
      step();

      // LB / LBU at a byte holding 0x80
      drive(1'b1, 1'b0, 3'b000, 32'h0000_0300, 32'h0, 5'd4, 1'b1);
      settle(); chk("lb_stall0", {31'd0, stall_req_o}, 32'd1);
      step(); settle();
      chk("lb_stall1", {31'd0, stall_req_o}, 32'd0);
      chk("lb_data", wdata_o, 32'hFFFF_FF80);
      step();
      drive(1'b1, 1'b0, 3'b100, 32'h0000_0300, 32'h0, 5'd4, 1'b1);
      settle(); chk("lbu_stall0", {31'd0, stall_req_o}, 32'd1);
      step(); settle();
      chk("lbu_stall1", {31'd0, stall_req_o}, 32'd0);
      chk("lbu_data", wdata_o, 32'h0000_0080);
      step();

      // LH with address wrap
      drive(1'b1, 1'b0, 3'b001, 32'h0001_FFFF, 32'h0, 5'd6, 1'b1);
      settle(); chk("lh_addr0", {15'd0, ram_addr_o}, 32'h1FFFF);
      step(); settle();
      chk("lh_addr1", {15'd0, ram_addr_o}, 32'h00000);
      chk("lh_stall1", {31'd0, stall_req_o}, 32'd1);
      step(); settle();
      chk("lh_data", wdata_o, 32'h0000_7FFF);
      chk("lh_stall2", {31'd0, stall_req_o}, 32'd0);
      step();

      // SW 0xDEADBEEF at 0x200
      drive(1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'hDEAD_BEEF, 5'd0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         logic [31:0] exp_w;
         exp_w = 32'hDEAD_BEEF >> (8 * k);
         settle();
         chk($sformatf("sw_addr%0d", k), {15'd0, ram_addr_o}, 32'h200 + k);
         chk($sformatf("sw_wr%0d", k), {31'd0, ram_wr_o}, 32'd1);
         chk($sformatf("sw_dout%0d", k), {24'd0, ram_dout_o}, {24'd0, exp_w[7:0]});
         chk($sformatf("sw_stall%0d", k), {31'd0, stall_req_o}, (k < 3) ? 32'd1 : 32'd0);
         chk($sformatf("sw_wreg%0d", k), {31'd0, wreg_o}, 32'd0);
         step();
      end
      // Read the stored word back
      drive(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd8, 1'b1);
      for (int c = 0; c < 4; c++) step();
      settle(); chk("sw_readback", wdata_o, 32'hDEAD_BEEF);
      step();

      // SB: one cycle, no stall
      drive(1'b0, 1'b1, 3'b000, 32'h0000_0210, 32'h1234_56A5, 5'd0, 1'b0);
      settle();
      chk("sb_addr", {15'd0, ram_addr_o}, 32'h210);
      chk("sb_wrd",  {23'd0, ram_wr_o, ram_dout_o}, {23'd0, 1'b1, 8'hA5});
      chk("sb_stall", {31'd0, stall_req_o}, 32'd0);
      step();

      // Reset in the middle of an LW
      drive(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd9, 1'b1);
      step(); step();
      rst = 1'b1;
      settle();
      chk("mrst_out", {ram_wr_o, stall_req_o, wreg_o, mem_fwd_we_o, 28'd0}, 32'd0);
      chk("mrst_data", wdata_o, 32'd0);
      step(); settle();
      chk("mrst_idle", {15'd0, ram_addr_o}, 32'd0);
      chk("mrst_stall", {31'd0, stall_req_o}, 32'd0);
      step();
      rst = 1'b0;
      drive(1'b0, 1'b1, 3'b000, 32'h0000_0220, 32'h0000_005A, 5'd0, 1'b0);
      settle();
      chk("post_sb_addr", {15'd0, ram_addr_o}, 32'h220);
      chk("post_sb_wrd", {23'd0, ram_wr_o, ram_dout_o}, {23'd0, 1'b1, 8'h5A});
      chk("post_sb_stall", {31'd0, stall_req_o}, 32'd0);
      step();
      drive(1'b1, 1'b0, 3'b100, 32'h0000_0220, 32'h0, 5'd10, 1'b1);
      settle(); chk("post_lbu_stall0", {31'd0, stall_req_o}, 32'd1);
      step(); settle();
      chk("post_lbu_data", wdata_o, 32'h0000_005A);
      step();
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
